// File: rtl/output_neuron_seq_if.sv
// Bundle of the output neuron's control handshake, operand and result signals.
// master: the side that launches computations (training/control logic).
// slave : the output neuron itself.
interface output_neuron_seq_if #(
  parameter int N_INPUTS = 8,
  parameter int X_W      = 10,
  parameter int W_W      = 8,
  parameter int ACC_W    = 23,
  parameter int T_W      = 4
);
  logic                       start_i;
  logic                       f0_pass_i;
  logic [T_W-1:0]             target_i;
  logic [N_INPUTS*X_W-1:0]    x_i;
  logic [N_INPUTS*W_W-1:0]    w_i;
  logic                       busy_o;
  logic                       done_o;
  logic [ACC_W-1:0]           final_o;
  logic [2*ACC_W+1:0]         loss_o;

  modport master (
    output start_i, f0_pass_i, target_i, x_i, w_i,
    input  busy_o, done_o, final_o, loss_o
  );

  modport slave (
    input  start_i, f0_pass_i, target_i, x_i, w_i,
    output busy_o, done_o, final_o, loss_o
  );
endinterface

// File: rtl/output_neuron_seq.sv
// Sequential output neuron: one multiply-accumulate per cycle over N_INPUTS
// activation/weight pairs, followed by a squared-error loss against a target.
// Compile-time option: OUTPUT_NEURON_SAT_EN selects a saturating accumulator;
// without it the accumulator wraps modulo 2^ACC_W.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; operands captured on the accepting edge
// ACC   | one MAC per edge, index 0 .. N_INPUTS-1
// LOSS  | register final_o / loss_o, pulse done_o, return to IDLE
module output_neuron_seq #(
  parameter int N_INPUTS = 8,
  parameter int X_W      = 10,
  parameter int W_W      = 8,
  parameter int ACC_W    = 23,
  parameter int T_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output_neuron_seq_if.slave   bus
);

  localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int PROD_W = X_W + W_W;
  localparam int LOSS_W = 2 * ACC_W + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_LOSS = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [N_INPUTS*X_W-1:0]   x_q, x_d;
  logic [N_INPUTS*W_W-1:0]   w_q, w_d;
  logic [T_W-1:0]            target_q, target_d;
  logic                      done_q, done_d;
  logic [ACC_W-1:0]          final_q, final_d;
  logic [LOSS_W-1:0]         loss_q, loss_d;

  logic [X_W-1:0]            x_sel;
  logic [W_W-1:0]            w_sel;
  logic [PROD_W-1:0]         prod;
  logic [ACC_W-1:0]          acc_next;

  logic signed [ACC_W:0]     diff;
  logic signed [LOSS_W-1:0]  diff_ext;
  logic signed [LOSS_W-1:0]  diff_sq;

  // Current MAC operands and their product.
  always_comb begin
    x_sel = x_q[idx_q * X_W +: X_W];
    w_sel = w_q[idx_q * W_W +: W_W];
    prod  = PROD_W'(x_sel) * PROD_W'(w_sel);
  end

`ifdef OUTPUT_NEURON_SAT_EN
  logic       sat_q, sat_d;
  logic [ACC_W:0] sum;

  // Saturating accumulate: once clamped, the accumulator stays at full scale.
  always_comb begin
    sum      = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    sat_d    = sat_q;
    acc_next = sum[ACC_W-1:0];
    if (sat_q || sum[ACC_W]) begin
      acc_next = {ACC_W{1'b1}};
      sat_d    = 1'b1;
    end
    if (state_q == ST_IDLE && bus.start_i) begin
      sat_d = 1'b0;
    end
  end

  // Sticky saturation flag, cleared when a new computation is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
`else
  // Wrapping accumulate: the carry out of ACC_W bits is simply dropped.
  always_comb begin
    acc_next = acc_q + ACC_W'(prod);
  end
`endif

  // Signed error against the target and its square.
  always_comb begin
    diff     = $signed({1'b0, acc_q}) - $signed((ACC_W + 1)'(target_q));
    diff_ext = LOSS_W'(diff);
    diff_sq  = diff_ext * diff_ext;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    w_d      = w_q;
    target_d = target_q;
    done_d   = 1'b0;
    final_d  = final_q;
    loss_d   = loss_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          x_d      = bus.x_i;
          w_d      = bus.w_i;
          target_d = bus.target_i;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_next;
        if (idx_q == IDX_LAST) begin
          state_d = ST_LOSS;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_LOSS: begin
        final_d = acc_q;
        if (bus.f0_pass_i && (acc_q != '0)) begin
          loss_d = $unsigned(diff_sq);
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      w_q      <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
      final_q  <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      w_q      <= w_d;
      target_q <= target_d;
      done_q   <= done_d;
      final_q  <= final_d;
      loss_q   <= loss_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.busy_o  = (state_q == ST_ACC) || (state_q == ST_LOSS);
    bus.done_o  = done_q;
    bus.final_o = final_q;
    bus.loss_o  = loss_q;
  end

endmodule

// File: tb/tb_output_neuron_seq.sv
// Directed testbench for output_neuron_seq (default build and ACC_W=20 build).
module tb_output_neuron_seq;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  output_neuron_seq_if #(.ACC_W(23)) bus ();
  output_neuron_seq_if #(.ACC_W(20)) bus20 ();

  output_neuron_seq #(.ACC_W(23)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  output_neuron_seq #(.ACC_W(20)) u_dut20 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus20.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int xv, input int wv, input int tv, input logic f0);
    for (int k = 0; k < 8; k++) begin
      bus.x_i[k*10 +: 10] = 10'(xv);
      bus.w_i[k*8 +: 8]   = 8'(wv);
    end
    bus.target_i  = 4'(tv);
    bus.f0_pass_i = f0;
  endtask

  // Pulse start for one edge, then wait (bounded) for done; returns edges after start edge.
  task automatic run_once(input string name, output int done_at);
    done_at = -1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.done_o) begin
        done_at = k;
        break;
      end
    end
    tests++;
    if (done_at < 0) begin
      fails++;
      $display("FAIL %s timeout: done_o never seen, required within 30 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus20.start_i = 1'b0;
    set_ops(0, 0, 0, 1'b0);
    bus20.x_i = '0; bus20.w_i = '0; bus20.target_i = '0; bus20.f0_pass_i = 1'b0;
    #22;
    tests += 4;
    if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    if (bus.final_o !== 23'd0) begin fails++; $display("FAIL reset_final got %0d want 0", bus.final_o); end
    if (bus.loss_o !== 48'd0) begin fails++; $display("FAIL reset_loss got %0d want 0", bus.loss_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int done_at, busy_cnt, done_cnt, overlap;
    set_ops(1, 128, 4, 1'b1);
    done_at = -1; busy_cnt = 0; done_cnt = 0; overlap = 0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin done_cnt++; if (done_at < 0) done_at = k - 1; end
      if (bus.done_o && bus.busy_o) overlap++;
      tick();
    end
    tests += 6;
    if (done_at !== 9) begin fails++; $display("FAIL basic_latency got %0d edges want 9", done_at); end
    if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_width got %0d cycles want 1", done_cnt); end
    if (busy_cnt !== 9) begin fails++; $display("FAIL basic_busy_len got %0d want 9", busy_cnt); end
    if (overlap !== 0) begin fails++; $display("FAIL basic_overlap got %0d want 0", overlap); end
    if (bus.final_o !== 23'd1024) begin fails++; $display("FAIL basic_final got %0d want 1024", bus.final_o); end
    if (bus.loss_o !== 48'd1040400) begin fails++; $display("FAIL basic_loss got %0d want 1040400", bus.loss_o); end
  endtask

  task automatic test_neg_diff();
    int done_at;
    set_ops(0, 1, 5, 1'b1);
    bus.x_i[9:0] = 10'd2;
    run_once("neg_diff", done_at);
    tests += 2;
    if (bus.final_o !== 23'd2) begin fails++; $display("FAIL neg_final got %0d want 2", bus.final_o); end
    if (bus.loss_o !== 48'd9) begin fails++; $display("FAIL neg_loss got %0d want 9", bus.loss_o); end
  endtask

  task automatic test_loss_hold();
    int done_at;
    tick();
    set_ops(0, 77, 3, 1'b1);
    run_once("zero_acc", done_at);
    tests += 2;
    if (bus.final_o !== 23'd0) begin fails++; $display("FAIL zero_final got %0d want 0", bus.final_o); end
    if (bus.loss_o !== 48'd9) begin fails++; $display("FAIL zero_loss got %0d want 9", bus.loss_o); end
    tick();
    set_ops(1, 128, 4, 1'b0);
    run_once("f0_low", done_at);
    tests += 2;
    if (bus.final_o !== 23'd1024) begin fails++; $display("FAIL f0_final got %0d want 1024", bus.final_o); end
    if (bus.loss_o !== 48'd9) begin fails++; $display("FAIL f0_loss got %0d want 9", bus.loss_o); end
  endtask

  task automatic test_back_to_back();
    int seen;
    int at [3];
    tick();
    set_ops(1, 1, 0, 1'b1);
    seen = 0;
    bus.start_i = 1'b1;
    tick();
    for (int k = 1; k <= 40 && seen < 3; k++) begin
      tick();
      if (bus.done_o) begin
        at[seen] = k;
        seen++;
      end
    end
    bus.start_i = 1'b0;
    tests += 3;
    if (seen !== 3) begin
      fails++; $display("FAIL b2b_count got %0d dones want 3", seen);
    end else if (at[0] !== 9 || at[1] !== 19 || at[2] !== 29) begin
      fails++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 9,19,29", at[0], at[1], at[2]);
    end
    if (bus.final_o !== 23'd8) begin fails++; $display("FAIL b2b_final got %0d want 8", bus.final_o); end
    if (bus.loss_o !== 48'd64) begin fails++; $display("FAIL b2b_loss got %0d want 64", bus.loss_o); end
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_start_ignored();
    int dones, done_at;
    set_ops(2, 1, 0, 1'b1);
    dones = 0; done_at = -1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      bus.start_i = (k == 3 || k == 8) ? 1'b1 : 1'b0;
      tick();
      if (bus.done_o) begin dones++; if (done_at < 0) done_at = k; end
    end
    bus.start_i = 1'b0;
    tests += 3;
    if (dones !== 1) begin fails++; $display("FAIL ignore_dones got %0d want 1", dones); end
    if (done_at !== 9) begin fails++; $display("FAIL ignore_latency got %0d want 9", done_at); end
    if (bus.final_o !== 23'd16) begin fails++; $display("FAIL ignore_final got %0d want 16", bus.final_o); end
  endtask

  task automatic test_overflow();
    int done_at;
    logic [19:0] want;
`ifdef OUTPUT_NEURON_SAT_EN
    want = 20'd1048575;
`else
    want = 20'd1038344;
`endif
    for (int k = 0; k < 8; k++) begin
      bus20.x_i[k*10 +: 10] = 10'd1023;
      bus20.w_i[k*8 +: 8]   = 8'd255;
    end
    bus20.target_i = 4'd0;
    bus20.f0_pass_i = 1'b1;
    done_at = -1;
    bus20.start_i = 1'b1;
    tick();
    bus20.start_i = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus20.done_o) begin done_at = k; break; end
    end
    tests += 2;
    if (done_at !== 9) begin fails++; $display("FAIL ovf_latency got %0d want 9", done_at); end
    if (bus20.final_o !== want) begin fails++; $display("FAIL ovf_final got %0d want %0d", bus20.final_o, want); end
  endtask

  task automatic test_reset_mid();
    int dones, done_at;
    tick();
    set_ops(3, 5, 1, 1'b1);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (bus.final_o !== 23'd0) begin fails++; $display("FAIL rmid_final got %0d want 0", bus.final_o); end
    if (bus.loss_o !== 48'd0) begin fails++; $display("FAIL rmid_loss got %0d want 0", bus.loss_o); end
    if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", bus.busy_o); end
    if (bus.done_o !== 1'b0) begin fails++; $display("FAIL rmid_done got %b want 0", bus.done_o); end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done_o || bus.busy_o) dones++;
    end
    tests++;
    if (dones !== 0) begin fails++; $display("FAIL rmid_no_done got %0d active cycles want 0", dones); end
    set_ops(1, 128, 4, 1'b1);
    run_once("rmid_rerun", done_at);
    tests += 3;
    if (done_at !== 9) begin fails++; $display("FAIL rmid_latency got %0d want 9", done_at); end
    if (bus.final_o !== 23'd1024) begin fails++; $display("FAIL rmid_final2 got %0d want 1024", bus.final_o); end
    if (bus.loss_o !== 48'd1040400) begin fails++; $display("FAIL rmid_loss2 got %0d want 1040400", bus.loss_o); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_neg_diff();
    test_loss_hold();
    test_back_to_back();
    test_start_ignored();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_neuron_seq.md
Name: output_neuron_seq

Overview:
- Parametrised, sequential successor to the 8-input output neuron.
- Computes a dot product of N unsigned activations and N unsigned 1.7 weights with one multiply-accumulate per cycle, under a start/done handshake.
- Then computes a squared-error loss against a small integer target.
- Sits at the output layer: hidden-neuron activations in; prediction and loss out to the training/control logic.

Parameters:
- N_INPUTS, 8, number of activation/weight pairs (≥1).
- X_W, 10, activation width (unsigned).
- W_W, 8, weight width (unsigned, 1.(W_W-1) fixed point).
- ACC_W, 23, accumulator and final_o width.
- T_W, 4, target width (unsigned).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  request a computation; sampled only in IDLE.
- f0_pass_i  in  1  loss-update qualifier; sampled at the LOSS edge.
- target_i  in  T_W  target value; captured with start.
- x_i  in  N_INPUTS*X_W  packed activations; element k is bits [k*X_W +: X_W].
- w_i  in  N_INPUTS*W_W  packed weights; element k is bits [k*W_W +: W_W].
- busy_o  out  1  high while in ACC or LOSS.
- done_o  out  1  one-cycle pulse when final_o and loss_o are updated.
- final_o  out  ACC_W  registered dot-product result.
- loss_o  out  2*ACC_W+2  registered squared error.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; index=0; accumulator=0; captured operands=0.
  - busy_o=0, done_o=0, final_o=0, loss_o=0.
  - Reset mid-operation aborts the computation; no done_o is generated.
- State IDLE:
  - start_i=1 at an edge → capture x_i, w_i, target_i into internal registers; clear accumulator and index; go to ACC.
  - Inputs may change freely after the capture edge.
- State ACC:
  - Each edge: accumulator += x[index]*w[index], both zero-extended.
  - The product is X_W+W_W bits; sum width is ACC_W+1 before the overflow rule.
  - On overflow past ACC_W bits, the accumulator wraps modulo 2^ACC_W (see Optional Feature).
  - index increments each edge. After the edge with index=N_INPUTS-1 → LOSS.
- State LOSS (one edge):
  - final_o <= accumulator.
  - diff = accumulator − target, signed, ACC_W+1 bits.
  - loss_o <= diff*diff only if f0_pass_i=1 and accumulator≠0; otherwise loss_o holds its previous value.
  - done_o <= 1; go to IDLE.
- Latency:
  - start captured at edge E0; MACs at E1..E_N; outputs register at E_(N+1).
  - done_o is high for exactly the cycle after E_(N+1).
  - Throughput: one result per N_INPUTS+2 cycles.
- Back-to-back: start_i is accepted in the same cycle done_o is high, because the state is already IDLE.
- start_i in ACC or LOSS is ignored; it is not queued.
- busy_o=1 in ACC and LOSS only. done_o is never high simultaneously with busy_o.
- final_o and loss_o hold their values between computations.

Optional Feature:
- Macro: OUTPUT_NEURON_SAT_EN.
- Defined: the accumulator saturates. If the ACC_W+1-bit sum exceeds 2^ACC_W−1, the accumulator clamps to 2^ACC_W−1 and stays there for the remaining MACs. A sticky internal flag is set and is cleared on start.
- Undefined: the accumulator wraps modulo 2^ACC_W.
- In both cases, loss uses the post-saturation/post-wrap accumulator value.

Test Plan:
- Defaults, all x=1, all w=128, target=4, f0_pass_i=1, start pulse:
  - done_o pulses 10 cycles after the start edge.
  - final_o=1024, loss_o=1040400.
  - busy_o high for exactly 9 cycles.
- x={2,0,0,0,0,0,0,0}, w={1,...}, target=5, f0_pass_i=1:
  - final_o=2.
  - diff=−3, loss_o=9 (negative-difference path).
- Following run with all x=0, any weights, f0_pass_i=1:
  - final_o=0; loss_o stays 9.
  - Repeat with f0_pass_i=0 and nonzero x: loss_o still 9, final_o updates.
- ACC_W=20 override, all x=1023, all w=255 (true sum 2086920):
  - With OUTPUT_NEURON_SAT_EN: final_o=1048575.
  - Without: final_o=2086920 mod 2^20 = 1038344.
- start_i held high continuously:
  - A new computation starts each time done_o is high; results every 10 cycles.
  - Pulses on start_i during busy are ignored.
- Assert rst_i=0 at MAC index 4:
  - All outputs 0 immediately.
  - No done_o pulse.
  - The next start runs a full, correct computation.
